cell_editor: RTL and testbench

Upstream edit stage for the game-of-life machine: debounces raw board buttons, owns the paused/running flag, the cell cursor and the edit grid. The evolve/step stage loads the edit grid whenever the machine is paused. On pause entry, the block snapshots the live grid so editing resumes from the current generation. It exposes cursor position and selected-cell state for the LCD/console visualizers.

---
 rtl/cell_editor_if.sv | 35 +++
 rtl/cell_editor.sv | 128 ++++++++++++
 tb/tb_cell_editor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cell_editor_if.sv
// Board-facing bundle for cell_editor: raw buttons and live grid in, edit grid,
// run/pause flag and cursor out.
interface cell_editor_if #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
);
    logic                      btn_left;
    logic                      btn_right;
    logic                      btn_up;
    logic                      btn_down;
    logic                      btn_toggle;
    logic                      btn_run;
    logic                      btn_clear;
    logic [WIDTH*HEIGHT-1:0]   live_grid;
    logic [WIDTH*HEIGHT-1:0]   edit_grid;
    logic                      paused;
    logic [$clog2(WIDTH)-1:0]  sel_x;
    logic [$clog2(HEIGHT)-1:0] sel_y;
    logic                      cell_selected;
    logic                      update_pulse;

    // Buttons are level signals with no handshake; update_pulse is a one-cycle
    // strobe that is high in the cycle after any edge that changed edit_grid.
    modport master (
        output btn_left, btn_right, btn_up, btn_down, btn_toggle, btn_run, btn_clear,
        output live_grid,
        input  edit_grid, paused, sel_x, sel_y, cell_selected, update_pulse
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down, btn_toggle, btn_run, btn_clear,
        input  live_grid,
        output edit_grid, paused, sel_x, sel_y, cell_selected, update_pulse
    );
endinterface

// File: rtl/cell_editor.sv
// Edit stage for the game-of-life board: debounced buttons drive the cursor,
// the edit grid and the run/pause state, with a live-grid snapshot on pause.
module cell_editor #(
    parameter int WIDTH    = 16,
    parameter int HEIGHT   = 16,
    parameter int DEBOUNCE = 250000
) (
    input logic         clk,
    input logic         rst_n,
    cell_editor_if.slave bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int GW = WIDTH * HEIGHT;
    localparam int IW = $clog2(GW);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int NB = 7;

    localparam int B_LEFT   = 0;
    localparam int B_RIGHT  = 1;
    localparam int B_UP     = 2;
    localparam int B_DOWN   = 3;
    localparam int B_TOGGLE = 4;
    localparam int B_RUN    = 5;
    localparam int B_CLEAR  = 6;

    typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1, sync2, lvl, lvl_q, press;
    logic [CW-1:0] cnt [NB];

    state_t        state, state_next;
    logic [GW-1:0] edit_grid;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic          update_pulse;
    logic [IW-1:0] cur_idx;

    assign raw = {bus.btn_clear, bus.btn_run, bus.btn_toggle, bus.btn_down,
                  bus.btn_up, bus.btn_right, bus.btn_left};

    // Counter measures how long the synchronized level has disagreed with the
    // accepted level; any agreement restarts the measurement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_q <= lvl;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE)) begin
                    lvl[i] <= ~lvl[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press = lvl & ~lvl_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_PAUSE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (press[B_CLEAR])
            state_next = ST_PAUSE;
        else if (press[B_RUN])
            state_next = (state == ST_PAUSE) ? ST_RUN : ST_PAUSE;
    end

    assign cur_idx = IW'(sel_y) * IW'(WIDTH) + IW'(sel_x);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edit_grid    <= '0;
            sel_x        <= '0;
            sel_y        <= '0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            if (press[B_CLEAR]) begin
                edit_grid    <= '0;
                sel_x        <= '0;
                sel_y        <= '0;
                update_pulse <= 1'b1;
            end else if (press[B_RUN]) begin
                // Snapshot on pause entry so editing resumes from this generation.
                if (state == ST_RUN) begin
                    edit_grid    <= bus.live_grid;
                    update_pulse <= 1'b1;
                end
            end else if (state == ST_PAUSE) begin
                if (press[B_TOGGLE]) begin
                    edit_grid[cur_idx] <= ~edit_grid[cur_idx];
                    update_pulse       <= 1'b1;
                end
                if (press[B_LEFT] && !press[B_RIGHT])
                    sel_x <= (sel_x == '0) ? XW'(WIDTH - 1) : sel_x - XW'(1);
                else if (press[B_RIGHT] && !press[B_LEFT])
                    sel_x <= (sel_x == XW'(WIDTH - 1)) ? '0 : sel_x + XW'(1);
                if (press[B_UP] && !press[B_DOWN])
                    sel_y <= (sel_y == '0) ? YW'(HEIGHT - 1) : sel_y - YW'(1);
                else if (press[B_DOWN] && !press[B_UP])
                    sel_y <= (sel_y == YW'(HEIGHT - 1)) ? '0 : sel_y + YW'(1);
            end
        end
    end

    assign bus.edit_grid     = edit_grid;
    assign bus.paused        = (state == ST_PAUSE);
    assign bus.sel_x         = sel_x;
    assign bus.sel_y         = sel_y;
    assign bus.cell_selected = edit_grid[cur_idx];
    assign bus.update_pulse  = update_pulse;
endmodule

// File: tb/tb_cell_editor.sv
// Directed bench for cell_editor on a 4x4 grid with a 4-cycle debounce:
// reset, debounce latency, wrap, simultaneous presses, run/snapshot, clear.
module tb_cell_editor;
  localparam int W = 4;
  localparam int H = 4;
  localparam int D = 4;

  // Button mask bit order: left, right, up, down, toggle, run, clear
  localparam logic [6:0] M_LEFT   = 7'b0000001;
  localparam logic [6:0] M_RIGHT  = 7'b0000010;
  localparam logic [6:0] M_UP     = 7'b0000100;
  localparam logic [6:0] M_DOWN   = 7'b0001000;
  localparam logic [6:0] M_TOGGLE = 7'b0010000;
  localparam logic [6:0] M_RUN    = 7'b0100000;
  localparam logic [6:0] M_CLEAR  = 7'b1000000;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   pulse_cnt;
  int   pulse_ref;

  cell_editor_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  cell_editor #(.WIDTH(W), .HEIGHT(H), .DEBOUNCE(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!rst_n) pulse_cnt <= 0;
    else if (bus.update_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] m);
    bus.btn_left   = m[0];
    bus.btn_right  = m[1];
    bus.btn_up     = m[2];
    bus.btn_down   = m[3];
    bus.btn_toggle = m[4];
    bus.btn_run    = m[5];
    bus.btn_clear  = m[6];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold long enough for one event, then release and let release debounce settle.
  task automatic press(input logic [6:0] m);
    drive(m);
    idle(8);
    drive(7'b0);
    idle(12);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.live_grid = '0;
    drive(7'b0);

    // reset and idle
    idle(2);
    rst_n = 1'b1;
    idle(20);
    check("rst_paused", 32'(bus.paused), 32'd1);
    check("rst_sel_x", 32'(bus.sel_x), 32'd0);
    check("rst_sel_y", 32'(bus.sel_y), 32'd0);
    check("rst_grid", 32'(bus.edit_grid), 32'h0);
    check("rst_cellsel", 32'(bus.cell_selected), 32'd0);
    check("rst_no_pulse", 32'(pulse_cnt), 32'd0);

    // 3-cycle glitch is rejected
    drive(M_TOGGLE);
    idle(3);
    drive(7'b0);
    idle(12);
    check("glitch_grid", 32'(bus.edit_grid), 32'h0);
    check("glitch_pulse", 32'(pulse_cnt), 32'd0);

    // press latency: first sampled at edge 0, visible after edge 7
    drive(M_TOGGLE);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("lat_edge6_grid", 32'(bus.edit_grid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge7_grid", 32'(bus.edit_grid), 32'h1);
    check("lat_edge7_pulse", 32'(bus.update_pulse), 32'd1);
    check("lat_edge7_cellsel", 32'(bus.cell_selected), 32'd1);
    @(negedge clk);
    check("lat_pulse_one_cycle", 32'(bus.update_pulse), 32'd0);
    idle(11);
    drive(7'b0);
    idle(12);
    check("held_single_event", 32'(pulse_cnt), 32'd1);
    check("held_grid", 32'(bus.edit_grid), 32'h1);

    // wrap-around
    press(M_LEFT);
    check("wrap_left_x", 32'(bus.sel_x), 32'd3);
    press(M_UP);
    check("wrap_up_y", 32'(bus.sel_y), 32'd3);
    press(M_TOGGLE);
    check("wrap_toggle_grid", 32'(bus.edit_grid), 32'h8001);
    check("wrap_cellsel", 32'(bus.cell_selected), 32'd1);

    // diagonal moves (3,3) -> (0,0) -> (1,1)
    press(M_RIGHT | M_DOWN);
    press(M_RIGHT | M_DOWN);
    check("diag_x", 32'(bus.sel_x), 32'd1);
    check("diag_y", 32'(bus.sel_y), 32'd1);

    // toggle + right: flip at old cursor, then move
    press(M_TOGGLE | M_RIGHT);
    check("togmove_grid", 32'(bus.edit_grid), 32'h8021);
    check("togmove_x", 32'(bus.sel_x), 32'd2);
    check("togmove_y", 32'(bus.sel_y), 32'd1);
    check("togmove_cellsel", 32'(bus.cell_selected), 32'd0);

    press(M_LEFT | M_RIGHT);
    check("lr_cancel_x", 32'(bus.sel_x), 32'd2);
    press(M_UP | M_DOWN);
    check("ud_cancel_y", 32'(bus.sel_y), 32'd1);

    // run: edits and moves ignored
    press(M_RUN);
    check("run_paused", 32'(bus.paused), 32'd0);
    check("run_grid_held", 32'(bus.edit_grid), 32'h8021);
    pulse_ref = pulse_cnt;
    press(M_TOGGLE);
    press(M_LEFT);
    press(M_DOWN);
    check("run_toggle_ignored", 32'(bus.edit_grid), 32'h8021);
    check("run_move_ignored_x", 32'(bus.sel_x), 32'd2);
    check("run_move_ignored_y", 32'(bus.sel_y), 32'd1);
    check("run_no_pulse", 32'(pulse_cnt - pulse_ref), 32'd0);

    // pause snapshots live grid
    bus.live_grid = 16'hA5A5;
    press(M_RUN);
    check("snap_paused", 32'(bus.paused), 32'd1);
    check("snap_grid", 32'(bus.edit_grid), 32'hA5A5);
    check("snap_pulse", 32'(pulse_cnt - pulse_ref), 32'd1);
    check("snap_cellsel", 32'(bus.cell_selected), 32'd0);

    // resume: grid held, no pulse
    pulse_ref = pulse_cnt;
    bus.live_grid = 16'h1234;
    press(M_RUN);
    check("resume_paused", 32'(bus.paused), 32'd0);
    check("resume_grid", 32'(bus.edit_grid), 32'hA5A5);
    check("resume_no_pulse", 32'(pulse_cnt - pulse_ref), 32'd0);

    // clear beats run
    press(M_CLEAR | M_RUN);
    check("clear_paused", 32'(bus.paused), 32'd1);
    check("clear_grid", 32'(bus.edit_grid), 32'h0);
    check("clear_x", 32'(bus.sel_x), 32'd0);
    check("clear_y", 32'(bus.sel_y), 32'd0);
    check("clear_pulse", 32'(pulse_cnt - pulse_ref), 32'd1);

    // reset mid-debounce discards the pending press
    drive(M_TOGGLE);
    idle(4);
    rst_n = 1'b0;
    idle(2);
    drive(7'b0);
    rst_n = 1'b1;
    idle(20);
    check("midrst_grid", 32'(bus.edit_grid), 32'h0);
    check("midrst_no_pulse", 32'(pulse_cnt), 32'd0);

    // button held through reset: event D+3 edges after release
    drive(M_TOGGLE);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("heldrst_edge6", 32'(bus.edit_grid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("heldrst_edge7", 32'(bus.edit_grid), 32'h1);
    drive(7'b0);
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
